// File: rtl/ps2_key_event_rx.sv
`default_nettype none
// ps2_key_event_rx: PS/2 frame receiver with E0/F0 prefix decode, event FIFO and held-key bitmap.
// Revision 1.0
module ps2_key_event_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic [4:0] key_held,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       overflow
);

  localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int IDLE_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW             = $clog2(FIFO_DEPTH);

  logic [2:0]        clk_sync;
  logic [1:0]        data_sync;
  logic              fe;
  logic              rx_bit;
  logic [3:0]        bit_cnt;
  logic [9:0]        frame;
  logic [IDLE_W-1:0] idle_cnt;
  logic              frame_ok;
  logic              frame_bad;
  logic              timeout_hit;
  logic              byte_stb;
  logic [7:0]        rx_byte;
  logic              ext;
  logic              brk;
  logic              emit;
  logic [4:0]        key_mask;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [9:0]        mem [FIFO_DEPTH];
  logic              full;
  logic              pop;
  logic              push;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], key_clk};
      data_sync <= {data_sync[0], key_data};
    end
  end

  assign fe     = clk_sync[2] & ~clk_sync[1];
  assign rx_bit = data_sync[1];

  // frame[0] = start, frame[8:1] = data, frame[9] = parity; the stop bit is the live bit
  assign frame_ok    = ~frame[0] & (^frame[9:1]) & rx_bit;
  assign frame_bad   = fe && (bit_cnt == 4'd10) && !frame_ok;
  assign timeout_hit = !fe && (bit_cnt != 4'd0) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt     <= 4'd0;
      frame       <= 10'd0;
      idle_cnt    <= '0;
      byte_stb    <= 1'b0;
      rx_byte     <= 8'd0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      byte_stb    <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      if (fe) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt   <= 4'd0;
          byte_stb  <= frame_ok;
          frame_err <= ~frame_ok;
          rx_byte   <= frame[8:1];
        end else begin
          frame   <= {rx_bit, frame[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout_hit) begin
          bit_cnt     <= 4'd0;
          idle_cnt    <= '0;
          timeout_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

  assign emit = byte_stb && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

  always_comb begin
    key_mask = 5'b00000;
    case (rx_byte)
      8'h1D:   key_mask = 5'b00001;
      8'h1B:   key_mask = 5'b00010;
      8'h1C:   key_mask = 5'b00100;
      8'h23:   key_mask = 5'b01000;
      8'h3B:   key_mask = 5'b10000;
      default: key_mask = 5'b00000;
    endcase
  end

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev_valid = (wr_ptr != rd_ptr);
  assign ev_data  = mem[rd_ptr[AW-1:0]];
  assign pop      = ev_valid && ev_ready;
  assign push     = emit && (!full || pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      key_held <= 5'b00000;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 10'd0;
    end else begin
      overflow <= emit && !push;
      if (timeout_hit || frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_stb) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
      // held bitmap tracks the keyboard even when the event itself is dropped
      if (emit && !ext) begin
        key_held <= brk ? (key_held & ~key_mask) : (key_held | key_mask);
      end
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= {ext, brk, rx_byte};
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_rx.sv
`default_nettype none
// tb_ps2_key_event_rx: scoreboard bench for the PS/2 key event receiver.
// Revision 1.0
module tb_ps2_key_event_rx;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [9:0] ev_data;
  logic [4:0] key_held;
  logic       frame_err;
  logic       timeout_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int terr_cnt = 0;
  int ovf_cnt = 0;
  logic [9:0] exp_q [$];

  ps2_key_event_rx dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .key_clk     (key_clk),
    .key_data    (key_data),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .key_held    (key_held),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  always #10 clk_in = ~clk_in;

  // pulse counters count high cycles, so a stretched pulse shows up as an extra count
  always @(negedge clk_in) begin
    if (frame_err)   ferr_cnt++;
    if (timeout_err) terr_cnt++;
    if (overflow)    ovf_cnt++;
  end

  always @(negedge clk_in) begin
    if (rst_n_in && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected: got %h, none expected", ev_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (ev_data !== e) begin
          errors++;
          $display("FAIL event_data: got %h, expected %h", ev_data, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      key_data = f[i];
      cyc(5);
      key_clk = 1'b0;
      cyc(10);
      key_clk = 1'b1;
      cyc(5);
    end
    key_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 1'b0, 11);
    cyc(20);
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    cyc(3);
    rst_n_in = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b, expected 0", ev_valid); end
    checks++; if (ev_data !== 10'h000) begin errors++; $display("FAIL reset_ev_data: got %h, expected 000", ev_data); end
    checks++; if (key_held !== 5'b00000) begin errors++; $display("FAIL reset_key_held: got %b, expected 00000", key_held); end
    checks++; if ({frame_err, timeout_err, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b, expected 000", {frame_err, timeout_err, overflow}); end
    // partial frame cut by reset must leave no trace
    send_bits(8'h1D, 1'b0, 4);
    do_reset();
    exp_q.push_back(10'h01D);
    send_byte(8'h1D);
    checks++; if (key_held !== 5'b00001) begin errors++; $display("FAIL midreset_held: got %b, expected 00001", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_drain: got %0d left, expected 0", exp_q.size()); end
    do_reset();
  endtask

  task automatic test_make_break();
    exp_q.push_back(10'h01D);
    send_byte(8'h1D);
    checks++; if (key_held !== 5'b00001) begin errors++; $display("FAIL make_w_held: got %b, expected 00001", key_held); end
    exp_q.push_back(10'h11D);
    send_byte(8'hF0);
    send_byte(8'h1D);
    checks++; if (key_held !== 5'b00000) begin errors++; $display("FAIL break_w_held: got %b, expected 00000", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL make_break_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(10'h01D); send_byte(8'h1D);
    exp_q.push_back(10'h023); send_byte(8'h23);
    exp_q.push_back(10'h03B); send_byte(8'h3B);
    checks++; if (key_held !== 5'b11001) begin errors++; $display("FAIL b2b_held: got %b, expected 11001", key_held); end
    exp_q.push_back(10'h123); send_byte(8'hF0); send_byte(8'h23);
    checks++; if (key_held !== 5'b10001) begin errors++; $display("FAIL b2b_break_d: got %b, expected 10001", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_extended();
    exp_q.push_back(10'h274); send_byte(8'hE0); send_byte(8'h74);
    exp_q.push_back(10'h374); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    checks++; if (key_held !== 5'b10001) begin errors++; $display("FAIL ext_held: got %b, expected 10001", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ext_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_frame_err();
    int base;
    base = ferr_cnt;
    send_bits(8'h1C, 1'b1, 11);
    cyc(20);
    checks++; if (ferr_cnt - base != 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles, expected 1", ferr_cnt - base); end
    checks++; if (key_held !== 5'b10001) begin errors++; $display("FAIL frame_err_held: got %b, expected 10001", key_held); end
    exp_q.push_back(10'h01C); send_byte(8'h1C);
    checks++; if (key_held !== 5'b10101) begin errors++; $display("FAIL frame_ok_held: got %b, expected 10101", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame_err_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    int base;
    exp_q.push_back(10'h13B); send_byte(8'hF0); send_byte(8'h3B);
    checks++; if (key_held !== 5'b00101) begin errors++; $display("FAIL timeout_pre_held: got %b, expected 00101", key_held); end
    base = terr_cnt;
    send_bits(8'h3B, 1'b0, 5);
    cyc(15000);
    checks++; if (terr_cnt - base != 1) begin errors++; $display("FAIL timeout_pulse: got %0d cycles, expected 1", terr_cnt - base); end
    exp_q.push_back(10'h03B); send_byte(8'h3B);
    checks++; if (key_held !== 5'b10101) begin errors++; $display("FAIL timeout_post_held: got %b, expected 10101", key_held); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_drain: got %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    int base;
    codes = '{8'h15, 8'h24, 8'h2D, 8'h2C, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h3B};
    do_reset();
    ev_ready = 1'b0;
    base = ovf_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back({2'b00, codes[i]});
      send_byte(codes[i]);
    end
    checks++; if (ovf_cnt - base != 1) begin errors++; $display("FAIL overflow_pulse: got %0d cycles, expected 1", ovf_cnt - base); end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL overflow_valid: got %b, expected 1", ev_valid); end
    checks++; if (ev_data !== 10'h015) begin errors++; $display("FAIL overflow_head_hold: got %h, expected 015", ev_data); end
    checks++; if (key_held !== 5'b11111) begin errors++; $display("FAIL overflow_held: got %b, expected 11111", key_held); end
    ev_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL overflow_drain: got %0d left, expected 0", exp_q.size()); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty: got %b, expected 0", ev_valid); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_back_to_back();
    test_extended();
    test_frame_err();
    test_timeout();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
